// File: rtl/instruction_memory_access.sv
// MEM stage: word-organised data memory with byte-lane stores, extended loads and a registered MEM/WB bundle.
// Latency 1 cycle; STALL freezes the MEM/WB registers and blocks memory writes.
module instruction_memory_access #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] EXMEM,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  input  logic        STALL,
  output logic [33:0] MEMWB,
  output logic [31:0] MEM_DATA,
  output logic [31:0] ALU_DATA,
  output logic        MISALIGNED
);

  logic              mem_rd;
  logic              mem_wr;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;

  assign mem_rd   = EXMEM[35];
  assign mem_wr   = EXMEM[34];
  assign funct3   = EXMEM[14:12];
  assign word_idx = ALU_RESULT[ADDR_W+1:2];
  assign byte_off = ALU_RESULT[1:0];

  logic [31:0] mem_q [DEPTH];

  logic        misal;
  logic        store_ok;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign rd_word  = mem_q[word_idx];
  assign byte_sel = rd_word[{byte_off, 3'b000} +: 8];
  assign half_sel = rd_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    misal = 1'b0;
    if (funct3[1:0] == 2'b01 && byte_off[0]) misal = 1'b1;
    if (funct3[1:0] == 2'b10 && byte_off != 2'b00) misal = 1'b1;
  end

  // Read-modify-write merge: untouched lanes carry the current word back.
  always_comb begin
    wr_word  = rd_word;
    store_ok = 1'b1;
    case (funct3)
      3'b000:  wr_word[{byte_off, 3'b000} +: 8]     = STORE_DATA[7:0];
      3'b001:  wr_word[{byte_off[1], 4'b0000} +: 16] = STORE_DATA[15:0];
      3'b010:  wr_word = STORE_DATA;
      default: store_ok = 1'b0;
    endcase
  end

  assign wr_en = mem_wr && store_ok && !misal && !STALL;

  always_comb begin
    load_ext = 32'h0;
    case (funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = rd_word;
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = 32'h0;
    endcase
  end

  // Array is never cleared; reset only blocks the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (wr_en) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  logic [33:0] memwb_d, memwb_q;
  logic [31:0] mem_data_d, mem_data_q;
  logic [31:0] alu_data_d, alu_data_q;
  logic        misal_d, misal_q;

  assign memwb_d    = {EXMEM[33], EXMEM[32], EXMEM[31:0]};
  assign mem_data_d = (mem_rd && !mem_wr && !misal) ? load_ext : 32'h0;
  assign alu_data_d = ALU_RESULT;
  assign misal_d    = (mem_rd || mem_wr) && misal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_q    <= '0;
      mem_data_q <= '0;
      alu_data_q <= '0;
      misal_q    <= 1'b0;
    end else if (!STALL) begin
      memwb_q    <= memwb_d;
      mem_data_q <= mem_data_d;
      alu_data_q <= alu_data_d;
      misal_q    <= misal_d;
    end
  end

  assign MEMWB      = memwb_q;
  assign MEM_DATA   = mem_data_q;
  assign ALU_DATA   = alu_data_q;
  assign MISALIGNED = misal_q;

endmodule

// File: tb/tb_instruction_memory_access.sv
// Directed bench for instruction_memory_access: reset, stores, extended loads, misalignment, stall.
module tb_instruction_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] EXMEM = '0;
  logic [31:0] ALU_RESULT = '0;
  logic [31:0] STORE_DATA = '0;
  logic        STALL = 1'b0;
  logic [33:0] MEMWB;
  logic [31:0] MEM_DATA;
  logic [31:0] ALU_DATA;
  logic        MISALIGNED;

  int total = 0;
  int bad   = 0;

  instruction_memory_access #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .EXMEM(EXMEM), .ALU_RESULT(ALU_RESULT),
    .STORE_DATA(STORE_DATA), .STALL(STALL), .MEMWB(MEMWB),
    .MEM_DATA(MEM_DATA), .ALU_DATA(ALU_DATA), .MISALIGNED(MISALIGNED)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ins(input logic [2:0] f3);
    return {12'h00A, 5'd2, f3, 5'd5, 7'h03};
  endfunction

  task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    EXMEM      = {mr, mw, mr, mr, mk_ins(f3)};
    ALU_RESULT = addr;
    STORE_DATA = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (MEMWB !== 34'h0) begin bad++; $display("FAIL reset_memwb got=%h exp=0", MEMWB); end
    total++; if (MEM_DATA !== 32'h0) begin bad++; $display("FAIL reset_mem_data got=%h exp=0", MEM_DATA); end
    total++; if (ALU_DATA !== 32'h0 || MISALIGNED !== 1'b0) begin bad++; $display("FAIL reset_alu_mis got=%h/%b exp=0/0", ALU_DATA, MISALIGNED); end
    rst = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h11111111);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'h11111111) begin bad++; $display("FAIL preload_0x10 got=%h exp=11111111", MEM_DATA); end
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h22222222);
    #3 rst = 1'b1;
    #1;
    total++; if (MEMWB !== 34'h0 || MEM_DATA !== 32'h0 || ALU_DATA !== 32'h0 || MISALIGNED !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h/%h/%h/%b exp=all zero", MEMWB, MEM_DATA, ALU_DATA, MISALIGNED);
    end
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'h11111111) begin bad++; $display("FAIL reset_blocks_write got=%h exp=11111111", MEM_DATA); end
  endtask

  task automatic test_store_load();
    drive(1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    tick();
    total++; if (MEM_DATA !== 32'h0 || ALU_DATA !== 32'h20) begin bad++; $display("FAIL sw_outputs got=%h/%h exp=0/20", MEM_DATA, ALU_DATA); end
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_0x20 got=%h exp=deadbeef", MEM_DATA); end
    total++; if (ALU_DATA !== 32'h20) begin bad++; $display("FAIL lw_alu got=%h exp=20", ALU_DATA); end
    total++; if (MEMWB !== {2'b11, mk_ins(3'b010)}) begin bad++; $display("FAIL lw_memwb got=%h exp=%h", MEMWB, {2'b11, mk_ins(3'b010)}); end
  endtask

  task automatic test_partial_store();
    drive(1'b0, 1'b1, 3'b000, 32'h21, 32'hFFFFFF55);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_merge got=%h exp=dead55ef", MEM_DATA); end
    drive(1'b0, 1'b1, 3'b001, 32'h22, 32'hABCD1234);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'h123455EF) begin bad++; $display("FAIL sh_merge got=%h exp=123455ef", MEM_DATA); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
    logic [31:0] adrs [5] = '{32'h31, 32'h31, 32'h30, 32'h30, 32'h32};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0, 32'h000080F0, 32'h00000000};
    drive(1'b0, 1'b1, 3'b010, 32'h30, 32'h000080F0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
      tick();
      total++; if (MEM_DATA !== exps[i]) begin bad++; $display("FAIL load_ext_%0d got=%h exp=%h", i, MEM_DATA, exps[i]); end
    end
  endtask

  task automatic test_misaligned();
    drive(1'b0, 1'b1, 3'b001, 32'h33, 32'h0000BEEF);
    tick();
    total++; if (MISALIGNED !== 1'b1 || MEM_DATA !== 32'h0) begin bad++; $display("FAIL sh_misaligned got=%b/%h exp=1/0", MISALIGNED, MEM_DATA); end
    drive(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    tick();
    total++; if (MISALIGNED !== 1'b1 || MEM_DATA !== 32'h0) begin bad++; $display("FAIL lw_misaligned got=%b/%h exp=1/0", MISALIGNED, MEM_DATA); end
    total++; if (MEMWB !== {2'b11, mk_ins(3'b010)}) begin bad++; $display("FAIL misaligned_memwb got=%h exp=%h", MEMWB, {2'b11, mk_ins(3'b010)}); end
    drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    tick();
    total++; if (MISALIGNED !== 1'b0 || MEM_DATA !== 32'h000080F0) begin bad++; $display("FAIL misaligned_no_write got=%b/%h exp=0/000080f0", MISALIGNED, MEM_DATA); end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h44, 32'h01020304);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'h12345678) begin bad++; $display("FAIL stall_preload got=%h exp=12345678", MEM_DATA); end
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'hAAAAAAAA);
    STALL = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (MEM_DATA !== 32'h12345678 || ALU_DATA !== 32'h40 || MEMWB !== {2'b11, mk_ins(3'b010)}) begin
        bad++; $display("FAIL stall_hold_%0d got=%h/%h/%h exp=12345678/40/%h", i, MEM_DATA, ALU_DATA, MEMWB, {2'b11, mk_ins(3'b010)});
      end
    end
    STALL = 1'b0;
    tick();
    total++; if (MEM_DATA !== 32'h0 || MEMWB !== {2'b00, mk_ins(3'b010)}) begin bad++; $display("FAIL stall_release got=%h/%h exp=0/%h", MEM_DATA, MEMWB, {2'b00, mk_ins(3'b010)}); end
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'hAAAAAAAA) begin bad++; $display("FAIL stall_write_lands got=%h exp=aaaaaaaa", MEM_DATA); end
    drive(1'b0, 1'b1, 3'b010, 32'h44, 32'h55555555);
    STALL = 1'b1;
    tick();
    STALL = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'h01020304) begin bad++; $display("FAIL stall_suppresses_write got=%h exp=01020304", MEM_DATA); end
  endtask

  task automatic test_back_to_back();
    EXMEM = {4'b0001, 32'h00B50533}; ALU_RESULT = 32'hCAFE0001; STORE_DATA = 32'h0;
    tick();
    total++; if (ALU_DATA !== 32'hCAFE0001 || MEM_DATA !== 32'h0 || MEMWB !== {2'b01, 32'h00B50533}) begin
      bad++; $display("FAIL passthrough got=%h/%h/%h exp=cafe0001/0/%h", ALU_DATA, MEM_DATA, MEMWB, {2'b01, 32'h00B50533});
    end
    drive(1'b1, 1'b1, 3'b010, 32'h424, 32'h0BADF00D);
    tick();
    total++; if (MEM_DATA !== 32'h0) begin bad++; $display("FAIL rw_as_store got=%h exp=0", MEM_DATA); end
    drive(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'h0BADF00D) begin bad++; $display("FAIL addr_wrap got=%h exp=0badf00d", MEM_DATA); end
    drive(1'b1, 1'b0, 3'b011, 32'h24, 32'h0);
    tick();
    total++; if (MEM_DATA !== 32'h0 || MISALIGNED !== 1'b0) begin bad++; $display("FAIL bad_funct3 got=%h/%b exp=0/0", MEM_DATA, MISALIGNED); end
  endtask

  initial begin
    #12;
    test_reset();
    test_store_load();
    test_partial_store();
    test_load_ext();
    test_misaligned();
    test_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
